// File: rtl/filtr_out_capture_pkg.sv
// Shared definitions for the filter output capture path: default sizes and FSM encoding.
package filtr_out_capture_pkg;

    localparam int DATA_SIZE_DEF   = 25;
    localparam int DEPTH_DEF       = 16;
    localparam int TIMEOUT_CYC_DEF = 1024;
    localparam int CNT_W_DEF       = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } cap_state_e;

endpackage

// File: rtl/filtr_out_fifo.sv
// Synchronous show-ahead FIFO; head word is read combinationally from storage.
module filtr_out_fifo
    import filtr_out_capture_pkg::*;
#(
    parameter int DW    = DATA_SIZE_DEF - 1,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          wr_fire;
    logic          rd_fire;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO still takes a write when popped.
    always_comb begin
        rd_fire  = rd_en && !empty;
        wr_fire  = wr_en && (!full || rd_fire);
        wr_ptr_d = wr_fire ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_fire ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({wr_fire, rd_fire})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/filtr_out_capture.sv
// Pairs each filter result with its sample strobe, queues it for the output sink and flags
// overrun, timeout and overflow conditions. Reader side: rd_valid = FIFO not empty, pop on rd_en.
module filtr_out_capture
    import filtr_out_capture_pkg::*;
#(
    parameter int DATA_SIZE   = DATA_SIZE_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    localparam int DW         = DATA_SIZE - 1,
    localparam int LW         = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample,
    input  logic [DW-1:0]    filt_data,
    input  logic             filter_done,
    input  logic             rd_en,
    output logic [DW-1:0]    rd_data,
    output logic             rd_valid,
    output logic [LW-1:0]    level,
    output logic             overrun,
    output logic             timeout,
    output logic             overflow,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    cap_state_e       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             sample_prev_q, done_prev_q;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic             sample_rise, done_rise;
    logic             capture, pop, fifo_full, fifo_empty;

    assign sample_rise = sample && !sample_prev_q;
    assign done_rise   = filter_done && !done_prev_q;
    assign pop         = rd_en && rd_valid;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        overrun_d    = overrun_q;
        timeout_d    = timeout_q;
        capture      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A done rise here has no pending sample and is dropped silently.
                if (sample_rise) begin
                    state_d = ST_WAIT;
                    timer_d = '0;
                end
            end
            ST_WAIT: begin
                if (done_rise) begin
                    capture = 1'b1;
                    timer_d = '0;
                    state_d = sample_rise ? ST_WAIT : ST_IDLE;
                end else if (sample_rise) begin
                    overrun_d = 1'b1;
                    timer_d   = '0;
                end else if (timer_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                    timer_d   = '0;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        sample_cnt_d = capture ? sample_cnt_q + CNT_W'(1) : sample_cnt_q;
        overflow_d   = overflow_q || (capture && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            sample_prev_q <= 1'b0;
            done_prev_q   <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
            overflow_q    <= 1'b0;
            sample_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            sample_prev_q <= sample;
            done_prev_q   <= filter_done;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
            overflow_q    <= overflow_d;
            sample_cnt_q  <= sample_cnt_d;
        end
    end

    filtr_out_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (capture),
        .wr_data (filt_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rd_valid   = !fifo_empty;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;
    assign overflow   = overflow_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_filtr_out_capture.sv
// Directed bench for filtr_out_capture: capture latency, edge detection, overrun, timeout,
// FIFO full/overflow ordering and reset clearing.
module tb_filtr_out_capture;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample;
    logic [DW-1:0] filt_data;
    logic          filter_done;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [4:0]    level;
    logic          overrun;
    logic          timeout;
    logic          overflow;
    logic [15:0]   sample_cnt;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_word;

    always #5 clk = ~clk;

    filtr_out_capture #(
        .DATA_SIZE   (25),
        .DEPTH       (16),
        .TIMEOUT_CYC (64),
        .CNT_W       (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample      (sample),
        .filt_data   (filt_data),
        .filter_done (filter_done),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .level       (level),
        .overrun     (overrun),
        .timeout     (timeout),
        .overflow    (overflow),
        .sample_cnt  (sample_cnt)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        cyc(n);
        reset = 1'b0;
    endtask

    // Sample pulse, short wait, then a one-cycle done pulse carrying d.
    task automatic capture_one(input logic [DW-1:0] d);
        sample = 1'b1;
        cyc(1);
        sample = 1'b0;
        cyc(2);
        filt_data   = d;
        filter_done = 1'b1;
        cyc(1);
        filter_done = 1'b0;
        cyc(1);
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
    endtask

    initial begin
        sample      = 1'b0;
        filt_data   = '0;
        filter_done = 1'b0;
        rd_en       = 1'b0;
        reset       = 1'b1;
        cyc(10);
        check("rst_level", level, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_flags", {overrun, timeout, overflow}, 0);
        check("rst_cnt", sample_cnt, 0);
        reset = 1'b0;

        // 1: basic capture, 3-cycle sample pulse, done 40 cycles after sample rise
        sample = 1'b1;
        cyc(3);
        sample = 1'b0;
        cyc(37);
        filt_data   = 24'h00ABCD;
        filter_done = 1'b1;
        cyc(2);
        filter_done = 1'b0;
        check("t1_valid", rd_valid, 1);
        check("t1_data", rd_data, 24'h00ABCD);
        check("t1_level", level, 1);
        check("t1_cnt", sample_cnt, 1);
        check("t1_flags", {overrun, timeout, overflow}, 0);
        pop_one();
        check("t1_pop_level", level, 0);
        check("t1_pop_valid", rd_valid, 0);

        // 2: done held 10 cycles counts once
        sample = 1'b1;
        cyc(1);
        sample = 1'b0;
        cyc(5);
        filt_data   = 24'h111111;
        filter_done = 1'b1;
        cyc(10);
        filter_done = 1'b0;
        cyc(2);
        check("t2_level", level, 1);
        check("t2_data", rd_data, 24'h111111);
        check("t2_cnt", sample_cnt, 2);
        pop_one();

        // 3: two sample rises before done -> overrun, single entry
        sample = 1'b1;
        cyc(1);
        sample = 1'b0;
        cyc(19);
        sample = 1'b1;
        cyc(1);
        sample = 1'b0;
        cyc(5);
        filt_data   = 24'h222222;
        filter_done = 1'b1;
        cyc(1);
        filter_done = 1'b0;
        cyc(1);
        check("t3_overrun", overrun, 1);
        check("t3_level", level, 1);
        check("t3_data", rd_data, 24'h222222);
        check("t3_cnt", sample_cnt, 3);
        check("t3_timeout", timeout, 0);
        pop_one();

        // 4: timeout exactly 64 cycles after the sample rise edge
        do_reset(2);
        sample = 1'b1;
        cyc(1);
        sample = 1'b0;
        cyc(63);
        check("t4_no_timeout_yet", timeout, 0);
        cyc(1);
        check("t4_timeout", timeout, 1);
        check("t4_level", level, 0);
        // FSM is back in IDLE: a done rise now is spurious
        filt_data   = 24'h0BAD00;
        filter_done = 1'b1;
        cyc(1);
        filter_done = 1'b0;
        cyc(1);
        check("t4_spurious_level", level, 0);
        check("t4_spurious_cnt", sample_cnt, 0);
        // normal capture afterwards, with a pop request on the empty FIFO in the write cycle
        sample = 1'b1;
        cyc(1);
        sample = 1'b0;
        cyc(2);
        filt_data   = 24'h333333;
        filter_done = 1'b1;
        rd_en       = 1'b1;
        cyc(1);
        filter_done = 1'b0;
        rd_en       = 1'b0;
        check("t4_wr_pop_empty_level", level, 1);
        check("t4_data", rd_data, 24'h333333);
        check("t4_cnt", sample_cnt, 1);
        check("t4_overrun", overrun, 0);
        pop_one();

        // 4b: done and sample rise together in WAIT -> capture, stay WAIT, no overrun
        sample = 1'b1;
        cyc(1);
        sample = 1'b0;
        cyc(2);
        filt_data   = 24'h444444;
        filter_done = 1'b1;
        sample      = 1'b1;
        cyc(1);
        filter_done = 1'b0;
        sample      = 1'b0;
        cyc(2);
        filt_data   = 24'h555555;
        filter_done = 1'b1;
        cyc(1);
        filter_done = 1'b0;
        cyc(1);
        check("t4b_level", level, 2);
        check("t4b_overrun", overrun, 0);
        check("t4b_head", rd_data, 24'h444444);
        pop_one();
        check("t4b_second", rd_data, 24'h555555);
        pop_one();

        // 5: 17 captures into a 16-deep FIFO, then drain in order
        do_reset(2);
        exp_q.delete();
        for (int i = 0; i < 17; i++) begin
            exp_word = 24'hC00000 + 24'(i * 24'h000101);
            capture_one(exp_word);
            if (i < 16) exp_q.push_back(exp_word);
        end
        check("t5_level_full", level, 16);
        check("t5_overflow", overflow, 1);
        check("t5_cnt", sample_cnt, 17);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_word = exp_q.pop_front();
            check($sformatf("t5_pop%0d_data", i), rd_data, exp_word);
            check($sformatf("t5_pop%0d_valid", i), rd_valid, 1);
            cyc(1);
        end
        rd_en = 1'b0;
        check("t5_drained_valid", rd_valid, 0);
        check("t5_drained_level", level, 0);

        // 6: reset while WAIT with 5 entries and sticky flags set
        for (int i = 0; i < 5; i++) capture_one(24'h600000 + 24'(i));
        sample = 1'b1;
        cyc(1);
        sample = 1'b0;
        cyc(3);
        sample = 1'b1;
        cyc(1);
        sample = 1'b0;
        check("t6_pre_level", level, 5);
        check("t6_pre_overrun", overrun, 1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("t6_level", level, 0);
        check("t6_valid", rd_valid, 0);
        check("t6_flags", {overrun, timeout, overflow}, 0);
        check("t6_cnt", sample_cnt, 0);
        // a done rise right after reset finds the FSM in IDLE
        filter_done = 1'b1;
        cyc(1);
        filter_done = 1'b0;
        cyc(1);
        check("t6_post_level", level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
